qspi_arbiter: RTL and testbench
===============================

# qspi_arbiter

Round-robin arbiter that shares the single QSPI flash read controller between `NUM_REQ` APB-style requesters, such as scalar instruction fetch, the vector load unit and the debug port. It sits between those requesters and the flash controller's slave port. It serialises transfers, checks that each address falls in the flash window, and terminates writes locally because flash is read-only. It returns read data and an error flag to the granted requester only.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `WIN_HI`, default 8'h20: required value of `paddr[31:24]` for a valid flash access.

Ports:
- `s_pclk`, input, 1: the single clock; everything is synchronous to its rising edge.
- `s_preset`, input, 1: reset; synchronous and active-high.
- `req_psel`, input, NUM_REQ: per-requester select, held high until that requester's `req_pready`.
- `req_pwrite`, input, NUM_REQ: per-requester write flag.
- `req_paddr`, input, NUM_REQ*32: per-requester address; requester i occupies bits [i*32+:32].
- `req_pready`, output, NUM_REQ: one-hot, one-cycle completion strobe.
- `req_prdata`, output, 32: read data, shared by all requesters; valid only while some `req_pready` bit is 1.
- `req_pslverr`, output, 1: error flag, shared by all requesters; valid only with `req_pready`.
- `m_psel`, output, 1: select to the flash controller (read only).
- `m_paddr`, output, 32: latched address to the flash controller.
- `m_pready`, input, 1: completion from the flash controller.
- `m_prdata`, input, 32: data from the flash controller.
- `grant_id`, output, $clog2(NUM_REQ): index of the current or most recent owner.
- `busy`, output, 1: high in every state except ARB.

## Operation
- The FSM has four states: ARB, FLASH, LOCAL, RESP.
- **Reset.** The FSM goes to ARB and the round-robin pointer `rr_ptr` goes to 0. These outputs reset to 0: `m_psel`, `m_paddr`, `req_pready`, `req_prdata`, `req_pslverr`, `grant_id`, `busy`.
- **ARB state.**
  - The winner is the first set bit of `req_psel` searching `rr_ptr`, `rr_ptr+1`, ..., wrapping modulo NUM_REQ.
  - If no bit is set, the FSM stays in ARB.
  - On a win: the winner's address goes into `m_paddr`, the winner's index into `grant_id`, and the error decision into `err_q`.
  - `err_q` = `req_pwrite[g]` OR (`req_paddr[g][31:24]` != `WIN_HI`).
  - Next state is LOCAL if `err_q` is set; otherwise FLASH, with `m_psel` set to 1.
- **FLASH state.**
  - `m_psel` is held at 1, and `m_paddr` is held stable.
  - On the edge where `m_pready`=1: clear `m_psel`, capture `m_prdata` into `req_prdata`, set `req_pslverr`=0, and go to RESP.
  - `m_psel` must be low the cycle after `m_pready`. The flash controller restarts on any psel it sees while idle.
- **LOCAL state.** Load `req_prdata`=32'h0 and `req_pslverr`=1, then go to RESP. Nothing is forwarded to the flash controller.
- **RESP state.**
  - `req_pready[grant_id]`=1 for exactly one cycle; all other bits are 0.
  - At the exit edge: `rr_ptr` becomes (`grant_id`+1) mod NUM_REQ, `req_pready` is cleared, and the FSM returns to ARB.
- **Requester protocol.**
  - Inputs are sampled only in ARB.
  - A requester must not change its `paddr`/`pwrite` while its `psel` is high and not yet acknowledged.
  - A requester that drops `psel` before being granted is simply not served; no error is raised.
  - A requester that lowers `psel` after its grant still receives `req_pready`; the transfer is not cancelled.
- **Fairness.** Under continuous requests from all requesters, grants rotate strictly. No requester waits more than NUM_REQ-1 transfers.
- **Reset mid-transfer.** Reset drops `m_psel` and returns the FSM to ARB. The flash controller shares the same reset, so no half-transfer survives.

## Timing
- **Request to select.** If `req_psel` is high in ARB at edge E0, `m_psel` is 1 after E0.
- **Flash response.** If `m_pready` is sampled at edge Ek, `req_pready` is high during cycle Ek..Ek+1 and the FSM is back in ARB after Ek+1.
- **Overhead.** The arbiter adds 2 cycles on top of the flash controller's psel-to-pready latency.
- **Local error.** Grant, LOCAL, RESP: `req_pready` is high in the third cycle after the request is sampled.
- **Back-to-back.** Minimum spacing between two grants is one ARB cycle. This is the cycle after RESP, in which the served requester may already present a new request.
- **Bus timing.** All outputs are registered, with no combinational path from inputs to outputs. `busy` is decoded from the registered state.

## Test plan
- **Single read.** Requester 0 reads 32'h2000_1234 against a flash model with latency 29 that returns 32'hCAFE_F00D. Required: `m_paddr`=32'h2000_1234; `m_psel` falls on the edge that samples `m_pready`; `req_pready`=2'b01 for one cycle with `req_prdata`=32'hCAFE_F00D and `req_pslverr`=0.
- **Round-robin.** With NUM_REQ=2, both requesters hold reads from reset. Required: the grant order is 0,1,0,1 over four transfers, and `m_psel` is never high in ARB or RESP.
- **Local errors.**
  - A write to 32'h2000_0000 gives `req_pslverr`=1 and `req_prdata`=0 three cycles after the request, and `m_psel` stays 0.
  - A read to 32'h3000_0000 gives the same response.
- **Withdrawn request.** Requester 1 pulses `psel` while requester 0 owns the flash, then drops it. Required: requester 1 gets no `req_pready`, and `rr_ptr` advances only on completed grants.
- **Mid-transfer reset.** Assert `s_preset` in FLASH 10 cycles after the grant. Required: the next cycle shows `m_psel`=0, `busy`=0, `req_pready`=0, and a request issued after reset is granted to requester 0.
- **Requester 0 is never unreachable.** With NUM_REQ=4 and all requesters continuously requesting, 8 transfers give the grant order 0,1,2,3,0,1,2,3.

Source files
------------

// File: rtl/qspi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qspi_arbiter : round-robin arbiter sharing one QSPI flash read port
//                between NUM_REQ APB-style requesters.
// Rev 1.0
// ---------------------------------------------------------------------------
module qspi_arbiter #(
  parameter int         NUM_REQ = 2,
  parameter logic [7:0] WIN_HI  = 8'h20
) (
  input  logic                       s_pclk,
  input  logic                       s_preset,
  input  logic [NUM_REQ-1:0]         req_psel,
  input  logic [NUM_REQ-1:0]         req_pwrite,
  input  logic [NUM_REQ*32-1:0]      req_paddr,
  output logic [NUM_REQ-1:0]         req_pready,
  output logic [31:0]                req_prdata,
  output logic                       req_pslverr,
  output logic                       m_psel,
  output logic [31:0]                m_paddr,
  input  logic                       m_pready,
  input  logic [31:0]                m_prdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int c_IDW = $clog2(NUM_REQ);

  localparam logic [1:0] c_ST_ARB   = 2'd0;
  localparam logic [1:0] c_ST_FLASH = 2'd1;
  localparam logic [1:0] c_ST_LOCAL = 2'd2;
  localparam logic [1:0] c_ST_RESP  = 2'd3;

  logic [1:0]         r_state;
  logic [c_IDW-1:0]   r_rr_ptr;
  logic [c_IDW-1:0]   r_grant_id;
  logic               r_m_psel;
  logic [31:0]        r_m_paddr;
  logic [NUM_REQ-1:0] r_req_pready;
  logic [31:0]        r_req_prdata;
  logic               r_req_pslverr;

  logic               w_found;
  logic [c_IDW-1:0]   w_win;
  logic [31:0]        w_win_addr;
  logic               w_win_wr;
  logic               w_err;
  logic [NUM_REQ-1:0] w_onehot;

  // (base + off) mod NUM_REQ, valid because both operands are below NUM_REQ
  function automatic logic [c_IDW-1:0] f_wrap(input logic [c_IDW-1:0] base, input int off);
    logic [c_IDW:0] s;
    s = {1'b0, base} + (c_IDW+1)'(off);
    if (s >= (c_IDW+1)'(NUM_REQ)) s = s - (c_IDW+1)'(NUM_REQ);
    return s[c_IDW-1:0];
  endfunction

  // Scan from the highest offset down so the offset closest to rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_psel[f_wrap(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = f_wrap(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_win_addr = '0;
    w_win_wr   = 1'b0;
    w_onehot   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == c_IDW'(i)) begin
        w_win_addr = req_paddr[i*32 +: 32];
        w_win_wr   = req_pwrite[i];
      end
      w_onehot[i] = (r_grant_id == c_IDW'(i));
    end
  end

  assign w_err = w_win_wr | (w_win_addr[31:24] != WIN_HI);

  always_ff @(posedge s_pclk) begin
    if (s_preset) begin
      r_state       <= c_ST_ARB;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_m_psel      <= 1'b0;
      r_m_paddr     <= '0;
      r_req_pready  <= '0;
      r_req_prdata  <= '0;
      r_req_pslverr <= 1'b0;
    end else begin
      case (r_state)
        c_ST_ARB: begin
          if (w_found) begin
            r_m_paddr  <= w_win_addr;
            r_grant_id <= w_win;
            if (w_err) begin
              r_state <= c_ST_LOCAL;
            end else begin
              r_state  <= c_ST_FLASH;
              r_m_psel <= 1'b1;
            end
          end
        end
        c_ST_FLASH: begin
          // psel must drop with the pready edge or the controller restarts
          if (m_pready) begin
            r_m_psel      <= 1'b0;
            r_req_prdata  <= m_prdata;
            r_req_pslverr <= 1'b0;
            r_req_pready  <= w_onehot;
            r_state       <= c_ST_RESP;
          end
        end
        c_ST_LOCAL: begin
          r_req_prdata  <= 32'h0;
          r_req_pslverr <= 1'b1;
          r_req_pready  <= w_onehot;
          r_state       <= c_ST_RESP;
        end
        default: begin
          r_req_pready <= '0;
          r_rr_ptr     <= f_wrap(r_grant_id, 1);
          r_state      <= c_ST_ARB;
        end
      endcase
    end
  end

  assign req_pready  = r_req_pready;
  assign req_prdata  = r_req_prdata;
  assign req_pslverr = r_req_pslverr;
  assign m_psel      = r_m_psel;
  assign m_paddr     = r_m_paddr;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state != c_ST_ARB);

endmodule
`default_nettype wire

// File: tb/tb_qspi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_qspi_arbiter : directed and randomized bench for qspi_arbiter (4 requesters)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_qspi_arbiter;

  localparam int N = 4;

  logic           s_pclk   = 1'b0;
  logic           s_preset = 1'b1;
  logic [N-1:0]   psel     = '0;
  logic [N-1:0]   pwrite   = '0;
  logic [N*32-1:0] paddr   = '0;
  logic [N-1:0]   req_pready;
  logic [31:0]    req_prdata;
  logic           req_pslverr;
  logic           m_psel;
  logic [31:0]    m_paddr;
  logic           m_pready = 1'b0;
  logic [31:0]    m_prdata = '0;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 s_pclk = ~s_pclk;

  qspi_arbiter #(.NUM_REQ(N), .WIN_HI(8'h20)) dut (
    .s_pclk(s_pclk), .s_preset(s_preset),
    .req_psel(psel), .req_pwrite(pwrite), .req_paddr(paddr),
    .req_pready(req_pready), .req_prdata(req_prdata), .req_pslverr(req_pslverr),
    .m_psel(m_psel), .m_paddr(m_paddr), .m_pready(m_pready), .m_prdata(m_prdata),
    .grant_id(grant_id), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- flash controller model ----------------
  int          fl_lat   = 29;
  int          fl_cnt   = 0;
  int          fl_cur   = 1;
  bit          fl_rand  = 1'b0;
  bit          fl_fixed = 1'b1;
  logic [31:0] fl_data  = 32'hCAFE_F00D;

  initial begin : flash_model
    bit r;
    forever begin
      @(posedge s_pclk);
      r = s_preset;
      #1;
      if (r) begin
        m_pready = 1'b0;
        fl_cnt   = 0;
      end else if (m_pready) begin
        m_pready = 1'b0;
      end else if (m_psel) begin
        if (fl_cnt == 0) fl_cur = fl_rand ? int'($urandom_range(1, 6)) : fl_lat;
        fl_cnt++;
        if (fl_cnt >= fl_cur) begin
          m_pready = 1'b1;
          m_prdata = fl_fixed ? fl_data : (m_paddr ^ 32'h5A5A_0F0F);
          fl_cnt   = 0;
        end
      end
    end
  end

  // ---------------- transaction-level arbiter model ----------------
  // activity: 0 idle, 1 waiting for flash, 2 local error, 3 responding
  bit          md_valid = 1'b0;
  int          md_act   = 0;
  int          md_ptr   = 0;
  int          exp_gid  = 0;
  logic        exp_msel = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [N-1:0] exp_pready = '0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err  = 1'b0;

  task automatic model_step();
    int w;
    if (s_preset) begin
      md_valid = 1'b1; md_act = 0; md_ptr = 0; exp_gid = 0;
      exp_msel = 1'b0; exp_addr = '0; exp_pready = '0; exp_rdata = '0; exp_err = 1'b0;
      return;
    end
    if (!md_valid) return;
    case (md_act)
      0: begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && psel[(md_ptr + k) % N]) w = (md_ptr + k) % N;
        if (w >= 0) begin
          exp_gid  = w;
          exp_addr = paddr[w*32 +: 32];
          if (pwrite[w] || exp_addr[31:24] != 8'h20) md_act = 2;
          else begin md_act = 1; exp_msel = 1'b1; end
        end
      end
      1: if (m_pready) begin
        exp_msel = 1'b0; exp_rdata = m_prdata; exp_err = 1'b0;
        exp_pready = N'(1 << exp_gid); md_act = 3;
      end
      2: begin
        exp_rdata = 32'h0; exp_err = 1'b1; exp_pready = N'(1 << exp_gid); md_act = 3;
      end
      default: begin
        exp_pready = '0; md_ptr = (exp_gid + 1) % N; md_act = 0;
      end
    endcase
  endtask

  initial forever begin
    @(posedge s_pclk);
    model_step();
  end

  int served[$];

  initial forever begin : compare
    @(negedge s_pclk);
    if (md_valid) begin
      chk("m_psel", 32'(m_psel), 32'(exp_msel));
      chk("m_paddr", m_paddr, exp_addr);
      chk("req_pready", 32'(req_pready), 32'(exp_pready));
      chk("grant_id", 32'(grant_id), 32'(exp_gid));
      chk("busy", 32'(busy), 32'(md_act != 0));
      if (exp_pready != '0) begin
        chk("req_prdata", req_prdata, exp_rdata);
        chk("req_pslverr", 32'(req_pslverr), 32'(exp_err));
      end
    end
    for (int i = 0; i < N; i++) if (req_pready[i]) served.push_back(i);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge s_pclk);
    #1;
  endtask

  task automatic do_reset();
    s_preset = 1'b1; psel = '0; pwrite = '0;
    tick();
    chk("rst_m_psel", 32'(m_psel), 32'h0);
    chk("rst_m_paddr", m_paddr, 32'h0);
    chk("rst_pready", 32'(req_pready), 32'h0);
    chk("rst_prdata", req_prdata, 32'h0);
    chk("rst_pslverr", 32'(req_pslverr), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    tick();
    s_preset = 1'b0;
    served.delete();
  endtask

  task automatic wait_pready(input string name, input logic [N-1:0] exp);
    logic [N-1:0] pr;
    pr = '0;
    for (int c = 0; c < 200 && pr == '0; c++) begin
      tick();
      pr = req_pready;
    end
    chk(name, 32'(pr), 32'(exp));
    psel = psel & ~pr;
    pwrite = pwrite & ~pr;
  endtask

  task automatic drain();
    psel = '0; pwrite = '0;
    for (int c = 0; c < 100 && busy; c++) tick();
    chk("drain_idle", 32'(busy), 32'h0);
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return {8'h30, 24'($urandom)};
    return {8'h20, 24'($urandom)};
  endfunction

  initial begin : main
    int t, t_sel;
    bit seen, prev_msel;

    do_reset();

    // single read, latency 29
    fl_lat = 29; fl_fixed = 1'b1; fl_data = 32'hCAFE_F00D;
    psel[0] = 1'b1; paddr[31:0] = 32'h2000_1234;
    t = 0; t_sel = 0; seen = 1'b0; prev_msel = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick(); t++;
      if (m_psel && !seen) begin
        seen = 1'b1; t_sel = t;
        chk("single_paddr", m_paddr, 32'h2000_1234);
      end
      if (req_pready != '0) break;
      prev_msel = m_psel;
    end
    chk("single_pready", 32'(req_pready), 32'h1);
    chk("single_prdata", req_prdata, 32'hCAFE_F00D);
    chk("single_pslverr", 32'(req_pslverr), 32'h0);
    chk("single_psel_fall", 32'({prev_msel, m_psel}), 32'h2);
    chk("single_latency", 32'(t - t_sel), 32'd29);
    psel[0] = 1'b0;
    tick();

    // withdrawn request from requester 1 while 0 owns the flash
    fl_lat = 20;
    psel[0] = 1'b1; paddr[31:0] = 32'h2000_0040;
    for (int c = 0; c < 5 && !m_psel; c++) tick();
    psel[1] = 1'b1; paddr[63:32] = 32'h2000_0080;
    repeat (3) tick();
    psel[1] = 1'b0;
    wait_pready("withdraw_owner", 4'b0001);
    tick();
    repeat (3) begin tick(); chk("withdraw_no_pready", 32'(req_pready), 32'h0); end
    fl_lat = 2;
    psel[0] = 1'b1; psel[1] = 1'b1;
    wait_pready("withdraw_ptr_next", 4'b0010);
    tick();
    wait_pready("withdraw_then_0", 4'b0001);
    tick();

    // local errors: write in window, read outside window
    psel[2] = 1'b1; pwrite[2] = 1'b1; paddr[95:64] = 32'h2000_0000;
    tick(); chk("lerr_w_psel0", 32'(m_psel), 32'h0);
    tick();
    chk("lerr_w_pready", 32'(req_pready), 32'b0100);
    chk("lerr_w_pslverr", 32'(req_pslverr), 32'h1);
    chk("lerr_w_prdata", req_prdata, 32'h0);
    chk("lerr_w_psel1", 32'(m_psel), 32'h0);
    psel[2] = 1'b0; pwrite[2] = 1'b0;
    tick();
    psel[1] = 1'b1; paddr[63:32] = 32'h3000_0000;
    tick(); tick();
    chk("lerr_r_pready", 32'(req_pready), 32'b0010);
    chk("lerr_r_pslverr", 32'(req_pslverr), 32'h1);
    chk("lerr_r_prdata", req_prdata, 32'h0);
    psel[1] = 1'b0;
    tick();

    // reset in the middle of a flash transfer (pointer sits at 2 beforehand)
    fl_lat = 29;
    psel[2] = 1'b1; paddr[95:64] = 32'h2000_0100;
    for (int c = 0; c < 5 && !m_psel; c++) tick();
    repeat (10) tick();
    chk("mid_busy_before", 32'(busy), 32'h1);
    s_preset = 1'b1;
    tick();
    chk("mid_m_psel", 32'(m_psel), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_pready", 32'(req_pready), 32'h0);
    s_preset = 1'b0; psel = '0;
    tick();
    fl_lat = 2;
    psel[0] = 1'b1; psel[3] = 1'b1; paddr[31:0] = 32'h2000_0200; paddr[127:96] = 32'h2000_0300;
    wait_pready("post_rst_first", 4'b0001);
    wait_pready("post_rst_second", 4'b1000);
    tick();

    // four requesters continuously requesting
    do_reset();
    fl_lat = 3;
    for (int i = 0; i < N; i++) paddr[i*32 +: 32] = 32'h2000_1000 + 32'(i * 4);
    psel = '1;
    for (int c = 0; c < 300 && served.size() < 8; c++) tick();
    for (int i = 0; i < 8; i++)
      chk("rr4_order", (i < served.size()) ? 32'(served[i]) : 32'hFFFF_FFFF, 32'(i % 4));
    drain();

    // two requesters continuously requesting
    do_reset();
    fl_lat = 5;
    psel = 4'b0011;
    for (int c = 0; c < 300 && served.size() < 4; c++) tick();
    for (int i = 0; i < 4; i++)
      chk("rr2_order", (i < served.size()) ? 32'(served[i]) : 32'hFFFF_FFFF, 32'(i % 2));
    drain();

    // randomized traffic
    do_reset();
    fl_rand = 1'b1; fl_fixed = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req_pready[i]) begin
          psel[i] = 1'b0; pwrite[i] = 1'b0;
        end else if (!psel[i] && $urandom_range(0, 3) == 0) begin
          paddr[i*32 +: 32] = rand_addr();
          pwrite[i] = ($urandom_range(0, 7) == 0);
          psel[i] = 1'b1;
        end else if (psel[i] && $urandom_range(0, 59) == 0) begin
          psel[i] = 1'b0;
        end
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
